// File: rtl/spi_memory_fsm.sv
// Transaction sequencer for the SPI memory datapath: counts SCLK edge pulses,
// waits for the shift register to settle, and raises the latch/load/write/MISO strobes.
module spi_memory_fsm #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       sclk_pos_edge,
  input  logic       sclk_neg_edge,
  input  logic       rw_bit,
  output logic       sr_parallel_load,
  output logic       addr_latch_we,
  output logic       dm_we,
  output logic       miso_buf_en,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_RX_ADDR      = 4'd1,
    S_ADDR_SETTLE  = 4'd2,
    S_ADDR_LATCH   = 4'd3,
    S_READ_LOAD    = 4'd4,
    S_READ_TX      = 4'd5,
    S_WRITE_RX     = 4'd6,
    S_WRITE_SETTLE = 4'd7,
    S_WRITE_COMMIT = 4'd8,
    S_DONE         = 4'd9
  } state_t;

  // Count value held just before the terminal pulse of each counting phase.
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_next;
  logic [CNT_W-1:0] w_bit_cnt_inc;

  assign w_bit_cnt_inc = r_bit_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
    end
  end

  // The counter is cleared whenever the state is not actively counting edges.
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = '0;
    if (r_state != S_IDLE && cs_n) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!cs_n) w_state_next = S_RX_ADDR;
        end
        S_RX_ADDR: begin
          w_bit_cnt_next = r_bit_cnt;
          if (sclk_pos_edge) begin
            if (r_bit_cnt == HDR_LAST) begin
              w_state_next   = S_ADDR_SETTLE;
              w_bit_cnt_next = '0;
            end else begin
              w_bit_cnt_next = w_bit_cnt_inc;
            end
          end
        end
        S_ADDR_SETTLE: w_state_next = S_ADDR_LATCH;
        S_ADDR_LATCH: begin
          w_state_next = rw_bit ? S_READ_LOAD : S_WRITE_RX;
        end
        S_READ_LOAD: w_state_next = S_READ_TX;
        S_READ_TX: begin
          w_bit_cnt_next = r_bit_cnt;
          if (sclk_neg_edge) begin
            if (r_bit_cnt == DATA_LAST) begin
              w_state_next   = S_DONE;
              w_bit_cnt_next = '0;
            end else begin
              w_bit_cnt_next = w_bit_cnt_inc;
            end
          end
        end
        S_WRITE_RX: begin
          w_bit_cnt_next = r_bit_cnt;
          if (sclk_pos_edge) begin
            if (r_bit_cnt == DATA_LAST) begin
              w_state_next   = S_WRITE_SETTLE;
              w_bit_cnt_next = '0;
            end else begin
              w_bit_cnt_next = w_bit_cnt_inc;
            end
          end
        end
        S_WRITE_SETTLE: w_state_next = S_WRITE_COMMIT;
        S_WRITE_COMMIT: w_state_next = S_DONE;
        S_DONE:         w_state_next = S_DONE;
        default:        w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sr_parallel_load = 1'b0;
    addr_latch_we    = 1'b0;
    dm_we            = 1'b0;
    miso_buf_en      = 1'b0;
    case (r_state)
      S_ADDR_LATCH:   addr_latch_we    = 1'b1;
      S_READ_LOAD:    sr_parallel_load = 1'b1;
      S_READ_TX:      miso_buf_en      = 1'b1;
      S_WRITE_COMMIT: dm_we            = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = r_state;

endmodule

// File: tb/tb_spi_memory_fsm.sv
// Bench for spi_memory_fsm: a directed vector table, hand sequences for abort and
// reset corners, and randomized traffic against a transaction-level model.
module tb_spi_memory_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       sclk_pos_edge;
  logic       sclk_neg_edge;
  logic       rw_bit;
  logic       sr_parallel_load;
  logic       addr_latch_we;
  logic       dm_we;
  logic       miso_buf_en;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  spi_memory_fsm #(.ADDR_BITS(7), .DATA_BITS(8), .CNT_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cs_n             (cs_n),
    .sclk_pos_edge    (sclk_pos_edge),
    .sclk_neg_edge    (sclk_neg_edge),
    .rw_bit           (rw_bit),
    .sr_parallel_load (sr_parallel_load),
    .addr_latch_we    (addr_latch_we),
    .dm_we            (dm_we),
    .miso_buf_en      (miso_buf_en),
    .state_dbg        (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs_n;
    logic       pos;
    logic       neg;
    logic       rw;
    logic [3:0] exp_state;
    logic       exp_load;
    logic       exp_latch;
    logic       exp_we;
    logic       exp_miso;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic c, input logic p, input logic ng,
                     input logic r, input int st);
    vec_t v;
    v.cs_n      = c;
    v.pos       = p;
    v.neg       = ng;
    v.rw        = r;
    v.exp_state = 4'(st);
    v.exp_latch = (st == 3);
    v.exp_load  = (st == 4);
    v.exp_miso  = (st == 5);
    v.exp_we    = (st == 8);
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare all outputs against what a given state must present.
  task automatic chk_all(input string tag, input int st);
    chk4({tag, " state_dbg"}, state_dbg, 4'(st));
    chk1({tag, " addr_latch_we"}, addr_latch_we, st == 3);
    chk1({tag, " sr_parallel_load"}, sr_parallel_load, st == 4);
    chk1({tag, " miso_buf_en"}, miso_buf_en, st == 5);
    chk1({tag, " dm_we"}, dm_we, st == 8);
  endtask

  task automatic drive(input logic c, input logic p, input logic ng, input logic r);
    cs_n          = c;
    sclk_pos_edge = p;
    sclk_neg_edge = ng;
    rw_bit        = r;
  endtask

  task automatic cyc(input logic c, input logic p, input logic ng, input logic r);
    drive(c, p, ng, r);
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: progress is tracked as edge counts and cycles
  // elapsed since each phase boundary; the visible state is derived from those.
  int m_in_txn, m_done, m_read, m_hdr, m_dat, m_t_hdr, m_t_dat;

  function automatic int model_state();
    if (m_in_txn == 0) return 0;
    if (m_done != 0) return 9;
    if (m_hdr < 8) return 1;
    if (m_t_hdr == 1) return 2;
    if (m_t_hdr == 2) return 3;
    if (m_read != 0 && m_t_hdr == 3) return 4;
    if (m_dat < 8) return (m_read != 0) ? 5 : 6;
    if (m_t_dat == 1) return 7;
    if (m_t_dat == 2) return 8;
    return 9;
  endfunction

  task automatic model_step(input logic c, input logic p, input logic ng, input logic r);
    int s;
    s = model_state();
    if (m_in_txn == 0) begin
      if (!c) begin
        m_in_txn = 1; m_done = 0; m_read = 0;
        m_hdr = 0; m_dat = 0; m_t_hdr = 0; m_t_dat = 0;
      end
    end else if (c) begin
      m_in_txn = 0;
    end else begin
      case (s)
        1: if (p) begin m_hdr++; if (m_hdr == 8) m_t_hdr = 1; end
        2: m_t_hdr = 2;
        3: begin m_read = r ? 1 : 0; m_t_hdr = 3; end
        4: m_t_hdr = 4;
        5: if (ng) begin m_dat++; if (m_dat == 8) m_done = 1; end
        6: if (p) begin m_dat++; if (m_dat == 8) m_t_dat = 1; end
        7: m_t_dat = 2;
        8: m_done = 1;
        default: ;
      endcase
    end
  endtask

  initial begin
    // Write transaction: first pulse coincides with cs_n fall and is ignored.
    add(1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1);
    add(1, 0, 0, 1, 0, 1);
    add(7, 0, 1, 0, 0, 1);
    add(1, 0, 1, 1, 0, 2);
    add(1, 0, 0, 0, 0, 3);
    add(1, 0, 1, 1, 0, 6);
    add(7, 0, 1, 0, 0, 6);
    add(1, 0, 0, 0, 0, 7);
    add(1, 0, 0, 0, 0, 8);
    add(1, 0, 1, 1, 0, 9);
    add(1, 1, 0, 0, 0, 9);
    add(1, 1, 0, 0, 0, 0);
    // Read transaction with a pos edge inside READ_TX.
    add(1, 0, 0, 0, 0, 0);
    add(8, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 1, 3);
    add(1, 0, 0, 0, 0, 4);
    add(1, 0, 0, 1, 0, 5);
    add(1, 0, 1, 0, 0, 5);
    add(7, 0, 0, 1, 0, 5);
    add(1, 0, 0, 0, 0, 9);
    add(1, 1, 0, 0, 0, 9);
    add(1, 1, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].cs_n, vecs[i].pos, vecs[i].neg, vecs[i].rw);
      chk4($sformatf("vec%0d state_dbg", i), state_dbg, vecs[i].exp_state);
      chk1($sformatf("vec%0d addr_latch_we", i), addr_latch_we, vecs[i].exp_latch);
      chk1($sformatf("vec%0d sr_parallel_load", i), sr_parallel_load, vecs[i].exp_load);
      chk1($sformatf("vec%0d miso_buf_en", i), miso_buf_en, vecs[i].exp_miso);
      chk1($sformatf("vec%0d dm_we", i), dm_we, vecs[i].exp_we);
      @(posedge clk);
      #1;
    end

    // Abort after 3 write-data edges, then a fresh transaction restarts counting.
    cyc(0, 0, 0, 0);
    repeat (8) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_all("abort pre", 6);
    repeat (3) cyc(0, 1, 0, 0);
    chk_all("abort mid", 6);
    cyc(1, 0, 0, 0);
    chk_all("abort idle", 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0);
      chk_all($sformatf("abort hold%0d", k), 0);
    end
    cyc(0, 0, 0, 0);
    chk_all("restart rx", 1);
    repeat (7) cyc(0, 1, 0, 0);
    chk_all("restart 7 edges", 1);
    cyc(0, 1, 0, 0);
    chk_all("restart settle", 2);
    cyc(0, 0, 0, 0);
    chk_all("restart latch", 3);
    cyc(1, 0, 0, 0);
    chk_all("restart abort", 0);
    cyc(1, 0, 0, 0);

    // Randomized traffic against the model.
    m_in_txn = 0; m_done = 0; m_read = 0;
    m_hdr = 0; m_dat = 0; m_t_hdr = 0; m_t_dat = 0;
    for (int k = 0; k < 3000; k++) begin
      int s, thr;
      logic c, p, ng, r;
      s   = model_state();
      thr = (s == 0) ? 30 : (s == 9) ? 40 : 2;
      c   = ($urandom_range(0, 99) < thr);
      p   = ($urandom_range(0, 2) == 0);
      ng  = ($urandom_range(0, 2) == 0);
      r   = $urandom_range(0, 1) == 1;
      drive(c, p, ng, r);
      chk_all($sformatf("rand%0d", k), s);
      model_step(c, p, ng, r);
      @(posedge clk);
      #1;
    end

    // Reset while in READ_TX: clears immediately, then stays idle with cs_n high.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (8) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk_all("rd before reset", 5);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk_all("rd mid", 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async reset state_dbg", state_dbg, 4'd0);
    chk1("async reset miso_buf_en", miso_buf_en, 1'b0);
    drive(1, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0);
      chk_all($sformatf("post reset%0d", k), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
